// File: rtl/effect_scheduler.sv
// Sequencer for the 7-digit seven-segment message display: loads the message into the
// effect engines, rotates the active effect and muxes the active engine onto the pins.
//
// state | meaning
// LOAD  | stream msg[0..6] over check/text_index, display dark, enable=7
// RUN   | active effect drives the display, dwell counting
// BLANK | dark gap between effects, then advance effect index
module effect_scheduler #(
    parameter int NUM_EFFECTS  = 4,
    parameter int DWELL_TICKS  = 250000000,
    parameter int BLANK_CYCLES = 12500000,
    parameter int HOLD         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     auto_mode,
    input  logic                     btn_next,
    input  logic                     btn_freq,
    input  logic                     wr_en,
    input  logic [2:0]               wr_addr,
    input  logic [6:0]               wr_char,
    input  logic [7*NUM_EFFECTS-1:0] eff_trans,
    input  logic [7*NUM_EFFECTS-1:0] eff_led,
    output logic [2:0]               enable,
    output logic [1:0]               frequency,
    output logic [3:0]               check,
    output logic [6:0]               text_index,
    output logic [6:0]               trans,
    output logic [6:0]               led7seg,
    output logic                     busy
);

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_BLANK} state_t;

    localparam int              HW         = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [27:0]     DWELL_LAST = 28'(DWELL_TICKS - 1);
    localparam logic [27:0]     BLANK_LAST = 28'(BLANK_CYCLES - 1);
    localparam logic [2:0]      EFF_LAST   = 3'(NUM_EFFECTS - 1);
    localparam logic [2:0]      SLOT_DONE  = 3'd7;

    state_t          state_q, state_d;
    logic [6:0]      msg_q [7];
    logic [6:0]      msg_d [7];
    logic [2:0]      effect_q, effect_d;
    logic [1:0]      frequency_q, frequency_d;
    logic            pending_q, pending_d;
    logic [2:0]      slot_q, slot_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [27:0]     dwell_q, dwell_d;
    logic [27:0]     blank_q, blank_d;
    logic [3:0]      check_q, check_d;
    logic [6:0]      text_index_q, text_index_d;
    logic [6:0]      trans_q, trans_d;
    logic [6:0]      led7seg_q, led7seg_d;

    logic            wr_valid;
    logic            ld_present;
    logic [2:0]      ld_slot;
    logic [HW-1:0]   ld_hold;

    assign wr_valid = wr_en && (wr_addr != 3'd7);

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        effect_d     = effect_q;
        frequency_d  = frequency_q;
        pending_d    = pending_q;
        slot_d       = slot_q;
        hold_d       = hold_q;
        dwell_d      = dwell_q;
        blank_d      = blank_q;
        check_d      = 4'd15;
        text_index_d = 7'd0;
        ld_present   = 1'b0;
        ld_slot      = slot_q;
        ld_hold      = hold_q;
        trans_d      = 7'h7F;
        led7seg_d    = 7'h7F;

        if (wr_valid) begin
            msg_d[wr_addr] = wr_char;
            pending_d      = 1'b1;
        end
        if (btn_freq) begin
            frequency_d = frequency_q + 2'd1;
        end

        case (state_q)
            ST_LOAD: begin
                if (slot_q == SLOT_DONE) begin
                    if (pending_q) begin
                        // chain straight into another pass; a write this cycle re-arms it
                        pending_d  = wr_valid;
                        ld_slot    = 3'd0;
                        ld_hold    = '0;
                        ld_present = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        dwell_d = 28'd0;
                        slot_d  = 3'd0;
                        hold_d  = '0;
                    end
                end else begin
                    ld_present = 1'b1;
                end
            end
            ST_RUN: begin
                dwell_d = dwell_q + 28'd1;
                if (wr_valid || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                    slot_d    = 3'd0;
                    hold_d    = '0;
                end else if ((auto_mode && (dwell_q == DWELL_LAST)) || btn_next) begin
                    state_d = ST_BLANK;
                    blank_d = 28'd0;
                end
            end
            ST_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    state_d  = ST_RUN;
                    effect_d = (effect_q == EFF_LAST) ? 3'd0 : effect_q + 3'd1;
                    dwell_d  = 28'd0;
                    blank_d  = 28'd0;
                end else begin
                    blank_d = blank_q + 28'd1;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (ld_present) begin
            check_d      = {1'b0, ld_slot};
            text_index_d = msg_q[ld_slot];
            if (ld_hold == HOLD_LAST) begin
                hold_d = '0;
                slot_d = ld_slot + 3'd1;
            end else begin
                hold_d = ld_hold + HW'(1);
                slot_d = ld_slot;
            end
        end

        if (state_d == ST_RUN) begin
            for (int k = 0; k < NUM_EFFECTS; k++) begin
                if (effect_d == 3'(k)) begin
                    trans_d   = eff_trans[7*k +: 7];
                    led7seg_d = eff_led[7*k +: 7];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            for (int i = 0; i < 7; i++) begin
                msg_q[i] <= 7'd0;
            end
            effect_q     <= 3'd0;
            frequency_q  <= 2'b01;
            pending_q    <= 1'b0;
            slot_q       <= 3'd0;
            hold_q       <= '0;
            dwell_q      <= 28'd0;
            blank_q      <= 28'd0;
            check_q      <= 4'd15;
            text_index_q <= 7'd0;
            trans_q      <= 7'h7F;
            led7seg_q    <= 7'h7F;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            effect_q     <= effect_d;
            frequency_q  <= frequency_d;
            pending_q    <= pending_d;
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
            check_q      <= check_d;
            text_index_q <= text_index_d;
            trans_q      <= trans_d;
            led7seg_q    <= led7seg_d;
        end
    end

    assign enable     = (state_q == ST_RUN) ? effect_q : 3'b111;
    assign busy       = (state_q == ST_LOAD);
    assign frequency  = frequency_q;
    assign check      = check_q;
    assign text_index = text_index_q;
    assign trans      = trans_q;
    assign led7seg    = led7seg_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Bench for effect_scheduler: vector table, hand sequences for multi-cycle corners,
// and a randomized run against a phase/countdown reference model.
module tb_effect_scheduler;

    localparam int NE    = 4;
    localparam int DWELL = 20;
    localparam int BLANK = 4;
    localparam int HOLD  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          auto_mode = 1'b0;
    logic          btn_next = 1'b0;
    logic          btn_freq = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = 3'd0;
    logic [6:0]    wr_char = 7'd0;
    logic [7*NE-1:0] eff_trans = '0;
    logic [7*NE-1:0] eff_led = '0;
    logic [2:0]    enable;
    logic [1:0]    frequency;
    logic [3:0]    check;
    logic [6:0]    text_index;
    logic [6:0]    trans;
    logic [6:0]    led7seg;
    logic          busy;

    int checks = 0;
    int errors = 0;

    effect_scheduler #(
        .NUM_EFFECTS(NE), .DWELL_TICKS(DWELL), .BLANK_CYCLES(BLANK), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .auto_mode(auto_mode), .btn_next(btn_next),
        .btn_freq(btn_freq), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .eff_trans(eff_trans), .eff_led(eff_led), .enable(enable),
        .frequency(frequency), .check(check), .text_index(text_index),
        .trans(trans), .led7seg(led7seg), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=LOAD 1=RUN 2=BLANK, m_cnt = edges spent in current phase
    int         m_mode, m_cnt, m_eff;
    bit         m_pend;
    logic [1:0] m_freq;
    logic [6:0] m_msg [7];
    logic [3:0] e_check;
    logic [6:0] e_text, e_trans, e_led;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_eff = 0; m_pend = 0; m_freq = 2'b01;
        for (int i = 0; i < 7; i++) m_msg[i] = 7'd0;
        e_check = 4'd15; e_text = 7'd0; e_trans = 7'h7F; e_led = 7'h7F;
    endtask

    task automatic model_step();
        bit wv = wr_en && (wr_addr != 3'd7);
        bit consumed = 0;
        e_check = 4'd15;
        e_text  = 7'd0;
        case (m_mode)
            0: begin
                if (m_cnt == 7*HOLD) begin
                    if (m_pend) begin
                        m_pend = 0; m_cnt = 1; e_check = 4'd0; e_text = m_msg[0];
                    end else begin
                        m_mode = 1; m_cnt = 0;
                    end
                end else begin
                    e_check = 4'(m_cnt / HOLD);
                    e_text  = m_msg[m_cnt / HOLD];
                    m_cnt++;
                end
            end
            1: begin
                if (wv || m_pend) begin
                    m_mode = 0; m_cnt = 0; m_pend = 0; consumed = 1;
                end else if ((auto_mode && m_cnt == DWELL-1) || btn_next) begin
                    m_mode = 2; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (m_cnt == BLANK-1) begin
                    m_mode = 1; m_cnt = 0; m_eff = (m_eff + 1) % NE;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        if (wv) begin
            m_msg[wr_addr] = wr_char;
            if (!consumed) m_pend = 1;
        end
        if (btn_freq) m_freq = m_freq + 2'd1;
        e_trans = (m_mode == 1) ? eff_trans[7*m_eff +: 7] : 7'h7F;
        e_led   = (m_mode == 1) ? eff_led[7*m_eff +: 7]   : 7'h7F;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        logic [2:0] e_en;
        model_step();
        @(posedge clk);
        #1;
        e_en = (m_mode == 1) ? 3'(m_eff) : 3'd7;
        checks++;
        if ({enable, frequency, check, text_index, trans, led7seg, busy} !==
            {e_en, m_freq, e_check, e_text, e_trans, e_led, (m_mode == 0)}) begin
            errors++;
            $display("FAIL model t=%0t: got en=%0d fq=%0d chk=%0d txt=%0d tr=%h led=%h busy=%0d, expected en=%0d fq=%0d chk=%0d txt=%0d tr=%h led=%h busy=%0d",
                     $time, enable, frequency, check, text_index, trans, led7seg, busy,
                     e_en, m_freq, e_check, e_text, e_trans, e_led, (m_mode == 0));
        end
    endtask

    task automatic measure(input logic [2:0] val, output int n);
        n = 0;
        while (enable == val && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_enable"}, enable, 7);
        chk({tag, "_freq"}, frequency, 1);
        chk({tag, "_check"}, check, 15);
        chk({tag, "_text"}, text_index, 0);
        chk({tag, "_trans"}, trans, 'h7F);
        chk({tag, "_led"}, led7seg, 'h7F);
        chk({tag, "_busy"}, busy, 1);
    endtask

    typedef struct {
        bit         auto_m;
        bit         nxt;
        bit         frq;
        logic [3:0] e_check;
        bit         e_busy;
        logic [2:0] e_en;
        logic [1:0] e_freq;
    } vec_t;

    vec_t tbl [39];

    initial begin
        int n, guard, last2, last5;

        // after-reset load, five frequency steps, then auto expiry at dwell 19
        for (int i = 0; i < 14; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 4'(i/2), 1'b1, 3'd7, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 3'd0, 2'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 3'd0, 2'd2};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 3'd0, 2'd2};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 3'd0, 2'd3};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 3'd0, 2'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 3'd0, 2'd1};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 3'd0, 2'd2};
        for (int i = 21; i < 34; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 3'd0, 2'd2};
        for (int i = 34; i < 38; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 3'd7, 2'd2};
        tbl[38] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 3'd1, 2'd2};

        model_reset();
        #22;
        chk_reset_values("reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 39; i++) begin
            auto_mode = tbl[i].auto_m;
            btn_next  = tbl[i].nxt;
            btn_freq  = tbl[i].frq;
            step();
            chk($sformatf("vec%0d_check", i), check, tbl[i].e_check);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_enable", i), enable, tbl[i].e_en);
            chk($sformatf("vec%0d_freq", i), frequency, tbl[i].e_freq);
        end
        btn_freq = 1'b0;

        // auto rotation through effects 1..3 and wrap to 0
        measure(3'd1, n); chk("run1_len", n, DWELL);
        measure(3'd7, n); chk("blank1_len", n, BLANK);
        measure(3'd2, n); chk("run2_len", n, DWELL);
        measure(3'd7, n); chk("blank2_len", n, BLANK);
        measure(3'd3, n); chk("run3_len", n, DWELL);
        measure(3'd7, n); chk("blank3_len", n, BLANK);
        chk("wrap_enable", enable, 0);

        // manual advance, pulse during BLANK ignored
        auto_mode = 1'b0;
        repeat (3) step();
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("manual_blank", enable, 7);
        step();
        btn_next = 1'b1; step(); btn_next = 1'b0;
        measure(3'd7, n); chk("blank_ignore_len", n, 2);
        chk("manual_next", enable, 1);

        // btn_next on the same edge as dwell expiry advances once
        repeat (DWELL-1) step();
        chk("pre_expiry", enable, 1);
        auto_mode = 1'b1; btn_next = 1'b1; step();
        auto_mode = 1'b0; btn_next = 1'b0;
        chk("coincide_blank", enable, 7);
        measure(3'd7, n); chk("coincide_blank_len", n, BLANK);
        chk("coincide_single", enable, 2);

        // reload with a second write mid-LOAD
        repeat (3) step();
        wr_en = 1'b1; wr_addr = 3'd2; wr_char = 7'd17; step(); wr_en = 1'b0;
        chk("reload_busy", busy, 1);
        chk("reload_enable", enable, 7);
        guard = 0;
        while (check != 4'd2 && guard < 40) begin step(); guard++; end
        chk("slot2_text", text_index, 17);
        wr_en = 1'b1; wr_addr = 3'd5; wr_char = 7'd33; step(); wr_en = 1'b0;
        n = 1; last2 = -1; last5 = -1;
        while (busy && n < 100) begin
            if (check == 4'd2) last2 = text_index;
            if (check == 4'd5) last5 = text_index;
            step();
            n++;
        end
        chk("reload_len", n, 24);
        chk("pass2_slot2", last2, 17);
        chk("pass2_slot5", last5, 33);
        chk("reload_same_effect", enable, 2);

        // display mux on effect 2
        eff_led = '0; eff_trans = '0;
        eff_led[20:14] = 7'h55; eff_trans[20:14] = 7'h3E;
        step();
        chk("mux_led", led7seg, 'h55);
        chk("mux_trans", trans, 'h3E);
        eff_led[20:14] = 7'h2A; eff_led[13:7] = 7'h11;
        step();
        chk("mux_led2", led7seg, 'h2A);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("mux_blank_led", led7seg, 'h7F);
        chk("mux_blank_trans", trans, 'h7F);
        measure(3'd7, n);

        // asynchronous reset mid-operation clears the buffer
        wr_en = 1'b1; wr_addr = 3'd0; wr_char = 7'd9; step(); wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_values("midrst");
        model_reset();
        #1 rst_n = 1'b1;
        step();
        chk("midrst_slot0", check, 0);
        chk("midrst_text0", text_index, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_en     = ($urandom % 16) == 0;
            wr_addr   = 3'($urandom);
            wr_char   = 7'($urandom);
            btn_next  = ($urandom % 20) == 0;
            btn_freq  = ($urandom % 10) == 0;
            if (($urandom % 50) == 0) auto_mode = ~auto_mode;
            eff_trans = 28'($urandom);
            eff_led   = 28'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/effect_scheduler.md
# effect_scheduler

Top-level sequencer for the 7-digit seven-segment message display. It holds the 7-character message buffer and loads it into every effect engine over the shared `check`/`text_index` bus. It selects which effect engine is active through `enable` and sets the animation `frequency`. It also arbitrates the physical display, muxing the active engine's digit-select and segment outputs onto the pins with a blanking gap between effects.

## Interface
Parameters:
- `NUM_EFFECTS`, default 4: number of effect engines; engine k is activated by `enable == k`.
- `DWELL_TICKS`, default 250000000: clk cycles each effect stays active in auto mode (5 s at 50 MHz).
- `BLANK_CYCLES`, default 12500000: clk cycles of dark display between effects.
- `HOLD`, default 2: clk cycles each character is held on the load bus.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `auto_mode`  in  1  level; 1 means advance on dwell expiry.
- `btn_next`  in  1  debounced one-cycle pulse; request the next effect.
- `btn_freq`  in  1  debounced one-cycle pulse; step the frequency.
- `wr_en`  in  1  message buffer write strobe.
- `wr_addr`  in  3  digit 0..6; writes with 7 are ignored.
- `wr_char`  in  7  character index to store.
- `eff_trans`  in  7*NUM_EFFECTS  digit selects; engine k occupies bits [7k+6:7k].
- `eff_led`  in  7*NUM_EFFECTS  segment patterns, same packing.
- `enable`  out  3  active-effect code.
- `frequency`  out  2  speed code: 00=0.5 Hz, 01=1 Hz, 10=2 Hz, 11=4 Hz.
- `check`  out  4  load-bus digit slot; 4'd15 means idle (no write).
- `text_index`  out  7  character presented for slot `check`.
- `trans`  out  7  physical digit select, active-low.
- `led7seg`  out  7  physical segments, active-low.
- `busy`  out  1  high while the LOAD state is active.

## Operation
- Reset values:
  - Outputs: `enable`=3'b111, `frequency`=2'b01, `check`=4'd15, `text_index`=0, `trans`=7'h7F, `led7seg`=7'h7F, `busy`=1.
  - Internal: buffer all 7'd0, effect=0, state=LOAD, slot=0, pending=0.
- FSM states:
  - LOAD:
    - `enable`=3'b111 and the display is dark.
    - Slot i (0..6) drives `check`=i and `text_index`=buf[i] for HOLD cycles.
    - After slot 6, go to RUN if pending=0. Otherwise clear pending and restart at slot 0.
  - RUN:
    - `enable`=effect and the display mux is active.
    - The dwell counter increments every cycle.
    - Go to BLANK when (`auto_mode` and dwell==DWELL_TICKS-1) or `btn_next`.
    - Go to LOAD when pending=1.
  - BLANK:
    - `enable`=3'b111 and the display is dark.
    - After BLANK_CYCLES, set effect=(effect+1) mod NUM_EFFECTS, clear dwell, go to RUN.
- Writes:
  - `wr_en` with `wr_addr`<7 updates buf[wr_addr] in any state and sets pending.
  - In RUN, pending forces LOAD on the next cycle, with priority over advance.
  - The effect index is kept across LOAD; dwell is cleared on re-entry to RUN.
- `btn_freq`: `frequency` increments mod 4 (11 wraps to 00) in any state. Dwell is unaffected.
- Ignored pulses: `btn_next` in LOAD or BLANK is dropped. `btn_next` coinciding with dwell expiry causes a single advance.
- Display mux: in RUN, `trans`/`led7seg` take the slice of engine `effect`; in other states they are 7'h7F.
- Counters: the dwell counter is 28 bits and saturates only through the state exit. The BLANK counter is 28 bits.

## Timing
- First LOAD slot appears on the first edge after `rst_n` deasserts. `busy` drops on the same edge that RUN is entered.
- A LOAD pass lasts 7*HOLD cycles (14 with defaults); `check` returns to 15 on RUN entry.
- Display mux is registered, so `trans`/`led7seg` follow `eff_*` with 1-cycle latency.
- `enable` changes on the same edge as the state change.
- `wr_en` in cycle t gives buffer valid at t+1. In RUN, LOAD is entered at t+1.
- `btn_next` at t gives BLANK at t+1; RUN with the new effect begins at t+1+BLANK_CYCLES.
- `rst_n` low mid-operation gives all reset values immediately (asynchronous); the buffer clears.

## Test plan
(Bench parameters: DWELL_TICKS=20, BLANK_CYCLES=4.)
- **Reset and load:** reset, then release -> `check` steps 0,0,1,1,…,6,6 with `text_index`=0; `busy` falls at cycle 14; `enable`=0.
- **Auto rotation:** `auto_mode`=1 -> after 20 RUN cycles `enable`=7 for 4 cycles, then 1. Effect 3 wraps to `enable`=0.
- **Manual advance:** `auto_mode`=0; pulse `btn_next` in RUN -> BLANK then `enable`=effect+1. A pulse during BLANK is ignored. A pulse coinciding with dwell expiry advances once.
- **Reload:** write `wr_addr`=2, `wr_char`=7'd17 in RUN -> `busy`=1 next cycle. The slot-2 window shows 17. RUN resumes with the same effect. A second write mid-LOAD triggers exactly one extra pass.
- **Display mux:** drive engine 2 `eff_led`=7'h55 while effect=2 -> `led7seg`=7'h55 one cycle later. It goes to 7'h7F during BLANK and LOAD.
- **Frequency:** 5 `btn_freq` pulses -> `frequency` sequence 01,10,11,00,01, with dwell count undisturbed.
